// File: rtl/or16_pkg.sv
// -----------------------------------------------------------------------------
// or16_pkg
// Shared constants and response entry layout for the Or16 request arbiter.
//   NREQ_DEF / WIDTH_DEF / DEPTH_DEF : default configuration of or16_arbiter
//   ID_W_DEF                         : requester tag width for the default NREQ
//   rsp_entry_t                      : response FIFO entry, {id, data}
// -----------------------------------------------------------------------------
package or16_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 2;
    localparam int ID_W_DEF  = $clog2(NREQ_DEF);

    // Entry layout for the default configuration; the top builds the same
    // {id, data} layout from its own parameters.
    typedef struct packed {
        logic [ID_W_DEF-1:0]  id;
        logic [WIDTH_DEF-1:0] data;
    } rsp_entry_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-set search.
//   req_i : request vector
//   ptr_i : index where the search starts (highest priority), wraps N-1 -> 0
//   gnt_o : one-hot grant of the first set request at or after ptr_i
//   idx_o : index of that request
//   any_o : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int k;
        logic found;
        // NOTE: every output gets a default before any conditional write so
        // no path leaves a value unassigned and no latch is inferred.
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int off = 0; off < N; off++) begin
            k = int'(ptr_i) + off;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req_i[IW'(k)]) begin
                found          = 1'b1;
                idx_o          = IW'(k);
                gnt_o[IW'(k)]  = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/or16_arbiter.sv
// -----------------------------------------------------------------------------
// or16_arbiter
// Shares one bitwise-OR datapath between NREQ requesters with round-robin
// arbitration; results are queued in a DEPTH-entry FIFO tagged with the id.
//   clk, rst_n   : clock, synchronous active-low reset
//   req_valid    : per-requester request
//   req_ready    : per-requester grant (one-hot or zero)
//   req_a, req_b : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid    : FIFO non-empty
//   rsp_ready    : consumer takes the head entry
//   rsp_out      : head result (last popped value while empty)
//   rsp_id       : requester index of the head result
// -----------------------------------------------------------------------------
module or16_arbiter
    import or16_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_out,
    output logic [IDW-1:0]        rsp_id
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [PW-1:0]  wr_q, wr_d;
    entry_t         last_q, last_d;
    entry_t         mem_q [DEPTH];

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            pop;
    logic            push;
    logic            can_accept;
    logic [WIDTH-1:0] push_data;
    entry_t          push_entry;
    entry_t          head;

    rr_pick #(.N(NREQ)) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Handshake outputs are forced low while reset is held so nothing is
    // accepted or popped on the reset edge.
    assign rsp_valid  = rst_n && (count_q != '0);
    assign pop        = rsp_valid && rsp_ready;
    // A full FIFO still accepts when its head leaves in the same cycle.
    assign can_accept = (count_q < CW'(DEPTH)) || pop;
    assign req_ready  = (rst_n && can_accept) ? pick_gnt : '0;
    assign push       = rst_n && can_accept && pick_any;

    assign push_data  = req_a[int'(pick_idx)*WIDTH +: WIDTH]
                      | req_b[int'(pick_idx)*WIDTH +: WIDTH];
    assign push_entry = {pick_idx, push_data};

    assign head    = mem_q[rd_q];
    assign rsp_out = (count_q != '0) ? head.data : last_q.data;
    assign rsp_id  = (count_q != '0) ? head.id   : last_q.id;

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        last_d  = last_q;
        if (push) begin
            wr_d  = wr_q + 1'b1;
            ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        if (pop) begin
            rd_d   = rd_q + 1'b1;
            last_d = head;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            last_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            last_q  <= last_d;
        end
    end

    // NOTE: FIFO storage has no reset; count_q gates every read, so stale
    // contents are never visible and the array can map to plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_or16_arbiter.sv
// -----------------------------------------------------------------------------
// tb_or16_arbiter
// Scoreboard bench for or16_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_or16_arbiter;
    import or16_pkg::*;

    localparam int NREQ  = NREQ_DEF;
    localparam int WIDTH = WIDTH_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_out;
    logic [IDW-1:0]        rsp_id;

    int checks = 0;
    int errors = 0;

    rsp_entry_t exp_q[$];
    rsp_entry_t last_seen;
    int         m_ptr;
    int         m_cnt;
    bit         fix_req2;

    or16_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one input pattern for n cycles with fresh random operands.
    task automatic cyc(input logic [NREQ-1:0] v, input logic rr, input int n);
        repeat (n) begin
            req_valid = v;
            rsp_ready = rr;
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
            if (fix_req2) begin
                req_a[2*WIDTH +: WIDTH] = 16'h00F0;
                req_b[2*WIDTH +: WIDTH] = 16'h0F00;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: decides the grant from the round-robin rule and the
    // modelled occupancy, and pushes the expected result on every transfer.
    always @(negedge clk) begin
        int             win;
        bit             pop_m;
        bit             can_m;
        logic [NREQ-1:0] exp_rdy;
        rsp_entry_t     e;
        if (!rst_n) begin
            check("reset_req_ready", 32'(req_ready), 32'd0);
            check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            m_ptr = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            pop_m   = (m_cnt > 0) && rsp_ready;
            can_m   = (m_cnt < DEPTH) || pop_m;
            win     = -1;
            exp_rdy = '0;
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && req_valid[(m_ptr + k) % NREQ]) begin
                    win = (m_ptr + k) % NREQ;
                end
            end
            if (win >= 0 && can_m) begin
                exp_rdy[win] = 1'b1;
            end
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(m_cnt > 0));
            if (win >= 0 && can_m) begin
                e.id   = IDW'(win);
                e.data = req_a[win*WIDTH +: WIDTH] | req_b[win*WIDTH +: WIDTH];
                exp_q.push_back(e);
                m_ptr = (win + 1) % NREQ;
                m_cnt = m_cnt + 1;
            end
            if (pop_m) begin
                m_cnt = m_cnt - 1;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        rsp_entry_t head;
        if (!rst_n) begin
            last_seen = '0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected actual=%0h/%0h required=none at %0t",
                         rsp_id, rsp_out, $time);
            end else begin
                head = exp_q[0];
                check("rsp_out", 32'(rsp_out), 32'(head.data));
                check("rsp_id", 32'(rsp_id), 32'(head.id));
                if (rsp_ready) begin
                    last_seen = head;
                    void'(exp_q.pop_front());
                end
            end
        end else begin
            check("idle_rsp_out", 32'(rsp_out), 32'(last_seen.data));
            check("idle_rsp_id", 32'(rsp_id), 32'(last_seen.id));
        end
    end

    initial begin
        fix_req2  = 1'b0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;

        // Reset with every requester asking, then full-rate round robin.
        cyc('1, 1'b1, 2);
        rst_n    = 1'b1;
        fix_req2 = 1'b1;
        cyc('1, 1'b1, 12);
        fix_req2 = 1'b0;

        // Backpressure: only requesters 1 and 3, consumer stalled, then drain.
        cyc('0, 1'b1, 2);
        cyc(4'b1010, 1'b0, 5);
        cyc(4'b1010, 1'b1, 4);

        // Pop and push on a full FIFO.
        cyc('0, 1'b1, 3);
        cyc('1, 1'b0, 3);
        cyc(4'b0001, 1'b1, 3);

        // Stalled winner: pointer at 2, FIFO full, then space frees.
        cyc('0, 1'b1, 3);
        cyc(4'b0001, 1'b0, 1);
        cyc(4'b0010, 1'b0, 1);
        cyc(4'b0101, 1'b0, 3);
        cyc(4'b0101, 1'b1, 4);

        // Reset while two results are queued.
        cyc('0, 1'b1, 3);
        cyc('1, 1'b0, 2);
        rst_n = 1'b0;
        cyc('1, 1'b0, 1);
        rst_n = 1'b1;
        cyc(4'b1100, 1'b1, 4);

        // Random traffic with occasional resets.
        repeat (400) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(NREQ'($urandom), ($urandom_range(0, 9) < 7), 1);
        end

        rst_n = 1'b1;
        cyc('0, 1'b1, 4);
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
